// File: rtl/tpg_avalon_csr_slave.sv
// Avalon-MM register file for the test pattern generator control path.
// Host writes land in staging registers; live words follow either immediately or at start-of-frame.
module tpg_avalon_csr_slave #(
   parameter int unsigned DW            = 32,
   parameter int unsigned REGS_NUM      = 4,
   parameter int unsigned ADDR_W        = 2,
   parameter bit          COMMIT_ON_SOF = 1'b1,
   parameter logic [REGS_NUM*DW-1:0] RST_VALS = {32'h0000FF03, 32'd600, 32'd800, 32'h00001033}
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [ADDR_W-1:0]      avs_address_i,
   input  logic                   avs_write_i,
   input  logic [DW-1:0]          avs_writedata_i,
   input  logic [DW/8-1:0]        avs_byteenable_i,
   input  logic                   avs_read_i,
   output logic [DW-1:0]          avs_readdata_o,
   output logic                   avs_readdatavalid_o,
   output logic                   avs_waitrequest_o,
   input  logic                   sof_i,
   output logic [REGS_NUM*DW-1:0] word_o,
   output logic [REGS_NUM-1:0]    word_valid_wr_o,
   output logic [REGS_NUM-1:0]    word_valid_rd_o,
   output logic                   commit_pending_o
);

   localparam int unsigned BE_W = DW / 8;

   typedef enum logic {ST_IDLE, ST_RD_RESP} state_t;

   state_t                  state_q;
   logic [DW-1:0]           readdata_q;
   logic                    readdatavalid_q;
   logic [REGS_NUM-1:0]     valid_rd_q;
   logic                    commit_pending_q;

   logic                    wr_accept;
   logic                    rd_accept;
   logic [REGS_NUM-1:0]     wr_hit;
   logic [REGS_NUM-1:0]     rd_hit;
   logic [DW-1:0]           rd_word;
   logic [REGS_NUM-1:0]     dirty_d_vec;
   logic [REGS_NUM-1:0]     valid_wr_vec;
   logic [REGS_NUM*DW-1:0]  staging_flat;
   logic [REGS_NUM*DW-1:0]  word_flat;

   // A simultaneous read is dropped in favour of the write.
   assign wr_accept = (state_q == ST_IDLE) && avs_write_i;
   assign rd_accept = (state_q == ST_IDLE) && avs_read_i && !avs_write_i;

   // Address decode; unmapped addresses hit nothing and read back as zero.
   always_comb begin
      rd_word = '0;
      wr_hit  = '0;
      rd_hit  = '0;
      for (int n = 0; n < int'(REGS_NUM); n++) begin
         if (avs_address_i == ADDR_W'(n)) begin
            rd_word   = staging_flat[n*DW +: DW];
            wr_hit[n] = wr_accept;
            rd_hit[n] = rd_accept;
         end
      end
   end

   for (genvar gi = 0; gi < int'(REGS_NUM); gi++) begin : g_reg
      logic [DW-1:0] stage_q;
      logic [DW-1:0] stage_d;
      logic [DW-1:0] live_q;
      logic          dirty_q;
      logic          dirty_d;
      logic          commit_en;
      logic          pulse_q;

      always_comb begin
         stage_d = stage_q;
         if (wr_hit[gi]) begin
            for (int b = 0; b < int'(BE_W); b++) begin
               if (avs_byteenable_i[b]) begin
                  stage_d[b*8 +: 8] = avs_writedata_i[b*8 +: 8];
               end
            end
         end
      end

      // A write landing on the commit cycle keeps dirty set and waits for the next commit.
      assign commit_en = COMMIT_ON_SOF ? (sof_i & dirty_q) : dirty_q;
      assign dirty_d   = wr_hit[gi] | (dirty_q & ~commit_en);

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            stage_q <= RST_VALS[gi*DW +: DW];
            live_q  <= RST_VALS[gi*DW +: DW];
            dirty_q <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            stage_q <= stage_d;
            dirty_q <= dirty_d;
            pulse_q <= commit_en;
            if (commit_en) begin
               live_q <= stage_q;
            end
         end
      end

      assign staging_flat[gi*DW +: DW] = stage_q;
      assign word_flat[gi*DW +: DW]    = live_q;
      assign dirty_d_vec[gi]           = dirty_d;
      assign valid_wr_vec[gi]          = pulse_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
         valid_rd_q      <= '0;
      end else if (state_q == ST_IDLE) begin
         readdatavalid_q <= 1'b0;
         valid_rd_q      <= '0;
         if (rd_accept) begin
            state_q         <= ST_RD_RESP;
            readdata_q      <= rd_word;
            readdatavalid_q <= 1'b1;
            valid_rd_q      <= rd_hit;
         end
      end else begin
         state_q         <= ST_IDLE;
         readdatavalid_q <= 1'b0;
         valid_rd_q      <= '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         commit_pending_q <= 1'b0;
      end else begin
         commit_pending_q <= COMMIT_ON_SOF & (|dirty_d_vec);
      end
   end

   assign avs_readdata_o      = readdata_q;
   assign avs_readdatavalid_o = readdatavalid_q;
   assign avs_waitrequest_o   = rst_i | (state_q == ST_RD_RESP);
   assign word_o              = word_flat;
   assign word_valid_wr_o     = valid_wr_vec;
   assign word_valid_rd_o     = valid_rd_q;
   assign commit_pending_o    = commit_pending_q;

endmodule
